tx_pkt_fifo: RTL and testbench

- Store-and-forward AXI-Stream frame buffer placed directly upstream of the MAC TX slave port (s_axis_* of the MAC/PCS top).
- Releases a frame only once its last beat is written. The MAC therefore never sees a mid-frame tvalid gap and cannot underrun the XGMII stream.
- Oversize frames are dropped. Optionally, frames flagged bad on tlast are also dropped.
- Single i_tx_clk domain.

---
 rtl/tx_pkt_fifo.sv | 160 ++++++++++++++++
 tb/tb_tx_pkt_fifo.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pkt_fifo.sv
// Store-and-forward AXI-Stream frame buffer in front of the MAC TX port; a frame is released only once fully stored.
// Optional feature macro: TX_PKT_FIFO_DROP_BAD_EN (discard frames whose tlast beat carries s_axis_tuser=1).
module tx_pkt_fifo #(
   parameter int N_SYMBOLS = 8,
   parameter int W_SYMBOL  = 8,
   parameter int DEPTH     = 64,
   parameter int W_CNT     = $clog2(DEPTH) + 1
) (
   input  logic                          i_tx_clk,
   input  logic                          i_tx_reset_n,
   input  logic                          s_axis_tvalid,
   input  logic [N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
   input  logic [N_SYMBOLS-1:0]          s_axis_tkeep,
   input  logic                          s_axis_tlast,
   input  logic                          s_axis_tuser,
   output logic                          s_axis_tready,
   output logic                          m_axis_tvalid,
   output logic [N_SYMBOLS*W_SYMBOL-1:0] m_axis_tdata,
   output logic [N_SYMBOLS-1:0]          m_axis_tkeep,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   output logic [W_CNT-1:0]              o_pkt_count,
   output logic                          o_drop
);

   localparam int               W_DATA  = N_SYMBOLS * W_SYMBOL;
   localparam int               W_ADDR  = $clog2(DEPTH);
   localparam int               W_WORD  = W_DATA + N_SYMBOLS + 1;
   localparam logic [W_CNT-1:0] L_DEPTH = W_CNT'(DEPTH);

`ifdef TX_PKT_FIFO_DROP_BAD_EN
   localparam bit L_DROP_BAD = 1'b1;
`else
   localparam bit L_DROP_BAD = 1'b0;
`endif

   typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_state_t;

   wr_state_t          r_state, w_state_nxt;
   logic [W_WORD-1:0]  r_mem [DEPTH];
   logic [W_CNT-1:0]   r_wr_ptr, r_wr_commit, r_rd_ptr, r_pkt_count;
   logic               r_init, r_drop;
   logic               r_out_valid, r_out_last;
   logic [W_DATA-1:0]  r_out_data;
   logic [N_SYMBOLS-1:0] r_out_keep;

   logic               w_full, w_oversize, w_s_ready;
   logic               w_wr_en, w_commit, w_rewind, w_drop_nxt;
   logic               w_fetch, w_pop;
   logic [W_WORD-1:0]  w_rd_word;

   assign w_full     = (r_wr_ptr - r_rd_ptr) == L_DEPTH;
   // A full buffer with no committed frame can only be holding one frame larger than the buffer.
   assign w_oversize = w_full && (r_pkt_count == '0);

   always_ff @(posedge i_tx_clk or negedge i_tx_reset_n) begin
      if (!i_tx_reset_n) begin
         r_state <= WR_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a value held (no latch).
      w_state_nxt = r_state;
      w_s_ready   = 1'b0;
      w_wr_en     = 1'b0;
      w_commit    = 1'b0;
      w_rewind    = 1'b0;
      w_drop_nxt  = 1'b0;
      case (r_state)
         WR_IDLE, WR_FRAME: begin
            w_s_ready = r_init && (!w_full || w_oversize);
            if (w_oversize) begin
               w_rewind = 1'b1;
               if (s_axis_tvalid && w_s_ready && s_axis_tlast) begin
                  w_drop_nxt  = 1'b1;
                  w_state_nxt = WR_IDLE;
               end else begin
                  w_state_nxt = WR_DROP;
               end
            end else if (s_axis_tvalid && w_s_ready) begin
               if (!s_axis_tlast) begin
                  w_wr_en     = 1'b1;
                  w_state_nxt = WR_FRAME;
               end else if (L_DROP_BAD && s_axis_tuser) begin
                  w_rewind    = 1'b1;
                  w_drop_nxt  = 1'b1;
                  w_state_nxt = WR_IDLE;
               end else begin
                  w_wr_en     = 1'b1;
                  w_commit    = 1'b1;
                  w_state_nxt = WR_IDLE;
               end
            end
         end
         WR_DROP: begin
            w_s_ready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               w_drop_nxt  = 1'b1;
               w_state_nxt = WR_IDLE;
            end
         end
         default: w_state_nxt = WR_IDLE;
      endcase
   end

   assign w_pop     = r_out_valid && m_axis_tready && r_out_last;
   assign w_fetch   = (r_pkt_count != '0) && (r_rd_ptr != r_wr_commit) && (!r_out_valid || m_axis_tready);
   assign w_rd_word = r_mem[r_rd_ptr[W_ADDR-1:0]];

   // NOTE: the storage array is not reset; pointers define which entries are valid.
   always_ff @(posedge i_tx_clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[W_ADDR-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   end

   always_ff @(posedge i_tx_clk or negedge i_tx_reset_n) begin
      if (!i_tx_reset_n) begin
         r_init      <= 1'b0;
         r_drop      <= 1'b0;
         r_wr_ptr    <= '0;
         r_wr_commit <= '0;
         r_rd_ptr    <= '0;
         r_pkt_count <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_keep  <= '0;
         r_out_data  <= '0;
      end else begin
         r_init <= 1'b1;
         r_drop <= w_drop_nxt;
         if (w_rewind)     r_wr_ptr <= r_wr_commit;
         else if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_commit)     r_wr_commit <= r_wr_ptr + 1'b1;
         case ({w_commit, w_pop})
            2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
            2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
            default: r_pkt_count <= r_pkt_count;
         endcase
         if (w_fetch) begin
            r_rd_ptr                               <= r_rd_ptr + 1'b1;
            r_out_valid                            <= 1'b1;
            {r_out_last, r_out_keep, r_out_data}   <= w_rd_word;
         end else if (m_axis_tready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign s_axis_tready = w_s_ready;
   assign m_axis_tvalid = r_out_valid;
   assign m_axis_tdata  = r_out_data;
   assign m_axis_tkeep  = r_out_keep;
   assign m_axis_tlast  = r_out_last;
   assign o_pkt_count   = r_pkt_count;
   assign o_drop        = r_drop;

endmodule

// File: tb/tb_tx_pkt_fifo.sv
// Self-checking bench for tx_pkt_fifo: a frame-level queue model checked every cycle plus directed literal checks.
// Expectations for tuser-flagged frames follow TX_PKT_FIFO_DROP_BAD_EN when the bench is built with it.
module tb_tx_pkt_fifo;

   localparam int DEPTH = 64;
   localparam int W_CNT = $clog2(DEPTH) + 1;

`ifdef TX_PKT_FIFO_DROP_BAD_EN
   localparam bit DROP_BAD = 1'b1;
`else
   localparam bit DROP_BAD = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             s_tvalid, s_tlast, s_tuser, s_tready;
   logic [63:0]      s_tdata;
   logic [7:0]       s_tkeep;
   logic             m_tvalid, m_tlast, m_tready;
   logic [63:0]      m_tdata;
   logic [7:0]       m_tkeep;
   logic [W_CNT-1:0] pkt_count;
   logic             drop;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;
   int n_last   = 0;
   int n_drops  = 0;
   int n_stall  = 0;

   beat_t exp_q[$];
   beat_t part_q[$];
   int    exp_cnt    = 0;
   logic  exp_drop   = 1'b0;
   logic  in_frame   = 1'b0;
   logic  prev_stall = 1'b0;
   beat_t prev_beat;

   tx_pkt_fifo #(.N_SYMBOLS(8), .W_SYMBOL(8), .DEPTH(DEPTH)) dut (
      .i_tx_clk     (clk),
      .i_tx_reset_n (rst_n),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tdata (s_tdata),
      .s_axis_tkeep (s_tkeep),
      .s_axis_tlast (s_tlast),
      .s_axis_tuser (s_tuser),
      .s_axis_tready(s_tready),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tdata (m_tdata),
      .m_axis_tkeep (m_tkeep),
      .m_axis_tlast (m_tlast),
      .m_axis_tready(m_tready),
      .o_pkt_count  (pkt_count),
      .o_drop       (drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic logic [63:0] beat_data(input int id, input int i);
      return {8'(id), 8'(i), 16'hA55A, 32'(id * 65536 + i * 7)};
   endfunction

   // Frame-level model: beats collect per frame, complete frames join the expected output queue.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_s_tready", s_tready, 0);
         check("rst_m_tvalid", m_tvalid, 0);
         check("rst_m_tlast", m_tlast, 0);
         check("rst_m_tdata", m_tdata, 0);
         check("rst_m_tkeep", m_tkeep, 0);
         check("rst_pkt_count", pkt_count, 0);
         check("rst_drop", drop, 0);
         exp_q.delete();
         part_q.delete();
         exp_cnt    = 0;
         exp_drop   = 1'b0;
         in_frame   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("pkt_count", pkt_count, 64'(exp_cnt));
         check("drop", drop, exp_drop);
         if (drop) n_drops++;
         if (in_frame) check("no_gap_valid", m_tvalid, 1);
         if (prev_stall) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_data", m_tdata, prev_beat.data);
            check("hold_keep", m_tkeep, 64'(prev_beat.keep));
            check("hold_last", m_tlast, 64'(prev_beat.last));
         end
         exp_drop = 1'b0;
         if (s_tvalid && s_tready) begin
            part_q.push_back('{data: s_tdata, keep: s_tkeep, last: s_tlast});
            if (s_tlast) begin
               if (part_q.size() > DEPTH || (DROP_BAD && s_tuser)) begin
                  exp_drop = 1'b1;
               end else begin
                  foreach (part_q[j]) exp_q.push_back(part_q[j]);
                  exp_cnt++;
               end
               part_q.delete();
            end
         end
         if (m_tvalid && m_tready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               fail("unexpected_out_beat");
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               check("out_data", m_tdata, b.data);
               check("out_keep", m_tkeep, 64'(b.keep));
               check("out_last", m_tlast, 64'(b.last));
            end
            if (m_tlast) begin
               n_last++;
               exp_cnt--;
               in_frame = 1'b0;
            end else begin
               in_frame = 1'b1;
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_beat  = '{data: m_tdata, keep: m_tkeep, last: m_tlast};
      end
   end

   // Drivers are called at posedge+1 and return at posedge+1 after the beat's handshake edge.
   task automatic put_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
      int   waited;
      logic hs;
      waited   = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      s_tuser  = u;
      do begin
         @(negedge clk);
         hs = s_tready;
         @(posedge clk);
         #1;
         if (!hs) begin
            n_stall++;
            waited++;
         end
      end while (!hs && waited < 500);
      if (!hs) fail("put_beat_timeout");
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic send_frame(input int id, input int len, input logic [7:0] last_keep,
                             input logic [7:0] first_keep, input logic user);
      for (int i = 0; i < len; i++) begin
         logic [7:0] k;
         k = (i == len - 1) ? last_keep : ((i == 0) ? first_keep : 8'hFF);
         put_beat(beat_data(id, i), k, i == len - 1, (i == len - 1) ? user : 1'b0);
      end
   endtask

   task automatic wait_drain(input int max_cycles);
      int c;
      c = 0;
      while ((pkt_count != 0 || m_tvalid) && c < max_cycles) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (c >= max_cycles) fail("drain_timeout");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int o0, l0, d0, s0;
      rst_n    = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
      m_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("tready_before_first_edge", s_tready, 0);
      @(posedge clk);
      #1;
      check("tready_after_first_edge", s_tready, 1);

      // Single 4-beat frame, last tkeep 0F, output ready.
      m_tready = 1'b1;
      o0 = n_out;
      send_frame(1, 4, 8'h0F, 8'hFF, 1'b0);
      check("t1_valid_after_e0", m_tvalid, 0);
      check("t1_count_after_e0", pkt_count, 1);
      @(posedge clk);
      #1;
      check("t1_valid_after_e1", m_tvalid, 1);
      check("t1_first_data", m_tdata, 64'h0100_A55A_0001_0000);
      wait_drain(20);
      check("t1_beats_out", 64'(n_out - o0), 4);
      check("t1_count_final", pkt_count, 0);

      // Three back-to-back 2-beat frames stored behind a stalled output.
      m_tready = 1'b0;
      send_frame(2, 2, 8'hFF, 8'hFF, 1'b0);
      send_frame(3, 2, 8'h01, 8'h00, 1'b0);
      send_frame(4, 2, 8'h80, 8'hFF, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("t2_count_stored", pkt_count, 3);
      check("t2_valid_stalled", m_tvalid, 1);
      o0 = n_out;
      l0 = n_last;
      m_tready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("t2_contiguous_beats", 64'(n_out - o0), 6);
      check("t2_tlast_count", 64'(n_last - l0), 3);
      check("t2_valid_after", m_tvalid, 0);
      check("t2_count_final", pkt_count, 0);

      // 70-beat frame into an empty 64-deep buffer: dropped without backpressure.
      s0 = n_stall;
      d0 = n_drops;
      o0 = n_out;
      send_frame(5, 70, 8'hFF, 8'hFF, 1'b0);
      check("t3_no_backpressure", 64'(n_stall - s0), 0);
      check("t3_drop_pulse", drop, 1);
      @(posedge clk);
      #1;
      check("t3_drop_one_cycle", drop, 0);
      check("t3_no_output", m_tvalid, 0);
      check("t3_count_zero", pkt_count, 0);
      send_frame(6, 3, 8'h03, 8'hFF, 1'b0);
      wait_drain(20);
      check("t3_follow_beats", 64'(n_out - o0), 3);
      check("t3_single_drop", 64'(n_drops - d0), 1);

      // Committed 40-beat frame plus 30-beat frame with output stalled: backpressure, no drop.
      m_tready = 1'b0;
      d0 = n_drops;
      o0 = n_out;
      send_frame(7, 40, 8'hFF, 8'hFF, 1'b0);
      s0 = n_stall;
      fork
         send_frame(8, 30, 8'h3F, 8'hFF, 1'b0);
         begin
            repeat (45) @(posedge clk);
            #1;
            check("t4_tready_full", s_tready, 0);
            check("t4_count_full", pkt_count, 1);
            m_tready = 1'b1;
         end
      join
      wait_drain(300);
      check("t4_beats_out", 64'(n_out - o0), 70);
      check("t4_no_drop", 64'(n_drops - d0), 0);
      check("t4_stalled", 64'(n_stall - s0 > 0), 1);

      // Reset mid-frame on both sides.
      m_tready = 1'b0;
      send_frame(9, 5, 8'hFF, 8'hFF, 1'b0);
      for (int i = 0; i < 3; i++) put_beat(beat_data(10, i), 8'hFF, 1'b0, 1'b0);
      m_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("t5_mid_read", m_tvalid, 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", m_tvalid, 0);
      check("t5_rst_count", pkt_count, 0);
      check("t5_rst_tready", s_tready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      o0 = n_out;
      send_frame(11, 3, 8'h1F, 8'hFF, 1'b0);
      wait_drain(20);
      check("t5_after_reset_beats", 64'(n_out - o0), 3);

      // Frame flagged bad on tlast, then a good frame.
      d0 = n_drops;
      o0 = n_out;
      send_frame(12, 3, 8'h07, 8'hFF, 1'b1);
      check("t6_drop_pulse", drop, DROP_BAD ? 1 : 0);
      @(posedge clk);
      #1;
      check("t6_drop_one_cycle", drop, 0);
      send_frame(13, 2, 8'hFF, 8'hFF, 1'b0);
      wait_drain(20);
      check("t6_beats_out", 64'(n_out - o0), DROP_BAD ? 2 : 5);
      check("t6_drops", 64'(n_drops - d0), DROP_BAD ? 1 : 0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
